// File: rtl/glitch_pkg.sv
// Shared types for the glitch sequence generator: FSM state encoding, default
// counter sizing and the shadow-configuration record captured on arm.
package glitch_pkg;

  localparam int GLITCH_CNT_W      = 32;
  localparam int GLITCH_MAX_PULSES = 8;
  localparam int GLITCH_CNT_P_W    = $clog2(GLITCH_MAX_PULSES + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } glitch_state_e;

  typedef struct packed {
    logic [GLITCH_CNT_W-1:0]   delay;
    logic [GLITCH_CNT_W-1:0]   width;
    logic [GLITCH_CNT_W-1:0]   gap;
    logic [GLITCH_CNT_P_W-1:0] count;
    logic                      trig_fall;
  } glitch_cfg_t;

  // Reload value for a duration counter: max(v,1) cycles means counting v-1 down to 0.
  function automatic logic [GLITCH_CNT_W-1:0] dur_reload(input logic [GLITCH_CNT_W-1:0] v);
    return (v == '0) ? '0 : v - GLITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a registered edge detector;
// edge_stb is a one-cycle strobe on the edge polarity chosen by trig_fall.
module trig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  input  logic trig_fall,
  output logic edge_stb
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= trig_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign edge_stb = trig_fall ? (r_prev & ~r_sync) : (r_sync & ~r_prev);

endmodule

// File: rtl/glitch_seq_gen.sv
// Programmable glitch pulse-train generator with arm/done handshake.
// Optional GLITCH_SEQ_AUTO_REARM_EN: DONE becomes a 1-cycle strobe and the block re-arms itself.
module glitch_seq_gen
  import glitch_pkg::*;
#(
  parameter  int   CNT_W      = GLITCH_CNT_W,
  parameter  int   MAX_PULSES = GLITCH_MAX_PULSES,
  parameter  logic GLITCH_POL = 1'b1,
  localparam int   CNT_P_W    = $clog2(MAX_PULSES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               trig_in,
  input  logic               trig_fall,
  input  logic [CNT_W-1:0]   cfg_delay,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic [CNT_P_W-1:0] cfg_count,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic               glitch
);

  glitch_state_e       r_state;
  glitch_cfg_t         r_cfg;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_P_W-1:0]  r_pcnt;
  logic                r_armed;
  logic                r_busy;
  logic                r_done;
  logic                r_glitch;

  logic                w_edge;
  logic                w_capture;
  logic [CNT_P_W-1:0]  w_count_clamped;
  logic [CNT_W-1:0]    w_delay;
  logic [CNT_W-1:0]    w_width_rl;
  logic [CNT_W-1:0]    w_gap_rl;

  trig_sync_edge u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_in   (trig_in),
    .trig_fall (r_cfg.trig_fall),
    .edge_stb  (w_edge)
  );

  // Config is only sampled when a fresh arm is legal; the shadow copy needs no reset.
  assign w_capture       = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_count_clamped = (cfg_count > CNT_P_W'(MAX_PULSES)) ? CNT_P_W'(MAX_PULSES) : cfg_count;

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_cfg.delay     <= GLITCH_CNT_W'(cfg_delay);
      r_cfg.width     <= GLITCH_CNT_W'(cfg_width);
      r_cfg.gap       <= GLITCH_CNT_W'(cfg_gap);
      r_cfg.count     <= GLITCH_CNT_P_W'(w_count_clamped);
      r_cfg.trig_fall <= trig_fall;
    end
  end

  assign w_delay    = CNT_W'(r_cfg.delay);
  assign w_width_rl = CNT_W'(dur_reload(r_cfg.width));
  assign w_gap_rl   = CNT_W'(dur_reload(r_cfg.gap));

  // Counters count down to zero, so the largest delay never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_armed  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_glitch <= ~GLITCH_POL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_edge) begin
            r_armed <= 1'b0;
            if (r_cfg.count == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DELAY;
              r_busy  <= 1'b1;
              r_cnt   <= w_delay;
              r_pcnt  <= CNT_P_W'(r_cfg.count);
            end
          end
        end
        ST_DELAY: begin
          if (r_cnt == '0) begin
            r_state  <= ST_PULSE;
            r_glitch <= GLITCH_POL;
            r_cnt    <= w_width_rl;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_glitch <= ~GLITCH_POL;
            r_pcnt   <= r_pcnt - CNT_P_W'(1);
            if (r_pcnt == CNT_P_W'(1)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_GAP;
              r_cnt   <= w_gap_rl;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_state  <= ST_PULSE;
            r_glitch <= GLITCH_POL;
            r_cnt    <= w_width_rl;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
`ifdef GLITCH_SEQ_AUTO_REARM_EN
          r_state <= ST_ARMED;
          r_done  <= 1'b0;
          r_armed <= 1'b1;
`else
          if (arm) begin
            r_state <= ST_ARMED;
            r_done  <= 1'b0;
            r_armed <= 1'b1;
          end
`endif
        end
        default: begin
          r_state  <= ST_IDLE;
          r_armed  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_glitch <= ~GLITCH_POL;
        end
      endcase
    end
  end

  assign armed  = r_armed;
  assign busy   = r_busy;
  assign done   = r_done;
  assign glitch = r_glitch;

endmodule

// File: tb/tb_glitch_seq_gen.sv
// Randomised bench for glitch_seq_gen: expected outputs per cycle come from the
// train timing rules (start, width, gap, count) evaluated with plain arithmetic.
module tb_glitch_seq_gen;

  localparam int   CW  = 8;
  localparam int   MP  = 8;
  localparam int   CPW = $clog2(MP + 1);
  localparam logic POL = 1'b1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           arm = 1'b0;
  logic           trig_in = 1'b0;
  logic           trig_fall = 1'b0;
  logic [CW-1:0]  cfg_delay = '0;
  logic [CW-1:0]  cfg_width = '0;
  logic [CW-1:0]  cfg_gap = '0;
  logic [CPW-1:0] cfg_count = '0;
  logic           armed;
  logic           busy;
  logic           done;
  logic           glitch;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  glitch_seq_gen #(
    .CNT_W      (CW),
    .MAX_PULSES (MP),
    .GLITCH_POL (POL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .trig_in   (trig_in),
    .trig_fall (trig_fall),
    .cfg_delay (cfg_delay),
    .cfg_width (cfg_width),
    .cfg_gap   (cfg_gap),
    .cfg_count (cfg_count),
    .armed     (armed),
    .busy      (busy),
    .done      (done),
    .glitch    (glitch)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: k counts clk edges after E0 (k=0 is E0 itself).
  function automatic int m_end(int d, int wc, int gc, int n);
    if (n == 0) return 2;
    return 3 + d + n * wc + (n - 1) * gc;
  endfunction

  function automatic bit m_glitch(int k, int d, int wc, int gc, int n);
    for (int i = 0; i < n; i++) begin
      int st = 3 + d + i * (wc + gc);
      if (k >= st && k < st + wc) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs(input int k, input int d, input int w, input int g, input int n);
    int wc = (w == 0) ? 1 : w;
    int gc = (g == 0) ? 1 : g;
    int e  = m_end(d, wc, gc, n);
    bit eg = m_glitch(k, d, wc, gc, n);
    bit eb = (n > 0) && (k >= 2) && (k < e);
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    bit ed = (k == e);
    bit ea = (k < 2) || (k > e);
`else
    bit ed = (k >= e);
    bit ea = (k < 2);
`endif
    check($sformatf("train.glitch k=%0d", k), glitch, eg ? POL : ~POL);
    check($sformatf("train.busy k=%0d", k), busy, eb);
    check($sformatf("train.done k=%0d", k), done, ed);
    check($sformatf("train.armed k=%0d", k), armed, ea);
  endtask

  task automatic scramble_cfg();
    cfg_delay = CW'($urandom);
    cfg_width = CW'($urandom);
    cfg_gap   = CW'($urandom);
    cfg_count = CPW'($urandom);
    trig_fall = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Arms with the given config, then drives a wrong-polarity edge that must be ignored.
  task automatic arm_train(input int d, input int w, input int g, input int c, input bit fall);
    bit act = !fall;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    do_reset();
`endif
    @(negedge clk);
    trig_in = act;
    repeat (4) @(negedge clk);
    cfg_delay = CW'(d);
    cfg_width = CW'(w);
    cfg_gap   = CW'(g);
    cfg_count = CPW'(c);
    trig_fall = fall;
    arm       = 1'b1;
    @(posedge clk); #1;
    check("arm.armed", armed, 1'b1);
    check("arm.done", done, 1'b0);
    @(negedge clk);
    arm = 1'b0;
    scramble_cfg();
    trig_in = ~act;
    repeat (6) begin
      @(posedge clk); #1;
      check("wrongpol.armed", armed, 1'b1);
      check("wrongpol.glitch", glitch, ~POL);
    end
    @(negedge clk);
    trig_in = act;
  endtask

  // Trigger already driven; next posedge is E0.
  task automatic watch_train(input int d, input int w, input int g, input int n, input bit noise, input bit act);
    int wc = (w == 0) ? 1 : w;
    int gc = (g == 0) ? 1 : g;
    int e  = m_end(d, wc, gc, n);
    for (int k = 0; k <= e + 3; k++) begin
      @(posedge clk); #1;
      check_outputs(k, d, w, g, n);
      @(negedge clk);
      arm = 1'b0;
      if (noise && k >= 2 && k < e - 6) begin
        if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
        if ($urandom_range(0, 4) == 0) begin
          arm = 1'b1;
          scramble_cfg();
        end
      end else if (k >= 2) begin
        trig_in = act;
      end
    end
  endtask

  task automatic after_train(input int d, input int w, input int g, input int n, input bit act);
    @(negedge clk);
    trig_in = ~act;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    repeat (90) @(negedge clk);
    @(posedge clk); #1;
    check("rearm.armed", armed, 1'b1);
    @(negedge clk);
    trig_in = act;
    watch_train(d, w, g, n, 1'b0, act);
`else
    repeat (4) @(negedge clk);
    trig_in = act;
    repeat (12) begin
      @(posedge clk); #1;
      check("retrig.glitch", glitch, ~POL);
      check("retrig.done", done, 1'b1);
      check("retrig.busy", busy, 1'b0);
      check("retrig.armed", armed, 1'b0);
    end
`endif
  endtask

  task automatic run(input int d, input int w, input int g, input int c, input bit fall, input bit noise);
    int n = (c > MP) ? MP : c;
    arm_train(d, w, g, c, fall);
    watch_train(d, w, g, n, noise, !fall);
    after_train(d, w, g, n, !fall);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.glitch", glitch, ~POL);
    check("reset.armed", armed, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(10, 5, 3, 1, 1'b0, 1'b0);
    run(4, 2, 4, 3, 1'b0, 1'b0);
    run(0, 2, 4, MP + 3, 1'b0, 1'b0);
    run(1, 0, 0, 4, 1'b0, 1'b0);
    run(5, 3, 3, 0, 1'b0, 1'b0);
    run(3, 3, 2, 2, 1'b1, 1'b0);
    run(255, 1, 1, 1, 1'b0, 1'b0);
    run(6, 4, 2, 3, 1'b1, 1'b1);

    for (int t = 0; t < 16; t++) begin
      run($urandom_range(0, 30), $urandom_range(0, 5), $urandom_range(0, 5),
          $urandom_range(0, 11), 1'($urandom), 1'b1);
    end

    // Asynchronous reset in the middle of a long pulse.
    arm_train(2, 20, 1, 1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
    end
    check("rst.pre_glitch", glitch, POL);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst.glitch", glitch, ~POL);
    check("rst.armed", armed, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("postrst.glitch", glitch, ~POL);
      check("postrst.armed", armed, 1'b0);
      check("postrst.busy", busy, 1'b0);
      check("postrst.done", done, 1'b0);
      @(negedge clk);
      trig_in = ~trig_in;
    end
    run(2, 3, 1, 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
